seg_mux_decoder: RTL and testbench

SEG_MUX_DECODER -- requirements
Module: seg_mux_decoder

---
 rtl/seg_mux_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg_mux_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_decoder.sv
// rtl/seg_mux_decoder.sv - debounced decoder for a two-digit multiplexed seven-segment bus.
// Defining SEG_DEC_ERRCNT_EN adds the saturating err_cnt output.
module seg_mux_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic       sel,
  output logic [3:0] left,
  output logic [3:0] right,
  output logic       left_vld,
  output logic       right_vld,
  output logic       upd,
  output logic       err
`ifdef SEG_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK  = 7'h7F;

  typedef enum logic {
    ACQ  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [6:0] s_seg;
  logic       s_sel;
  logic [7:0] cnt;
  logic       changed;
  logic       eval;

  logic       dec_ok;
  logic [3:0] dec_val;

  logic [3:0] left_nxt;
  logic [3:0] right_nxt;
  logic       left_vld_nxt;
  logic       right_vld_nxt;
  logic       upd_nxt;
  logic       err_nxt;

  // The counter compares the incoming sample against the one already held,
  // so it reads 1 right after the first edge of a new pattern.
  assign changed = {sel, seg} != {s_sel, s_seg};
  assign eval    = (state == ACQ) && (cnt == STABLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_seg <= BLANK;
      s_sel <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      s_seg <= seg;
      s_sel <= sel;
      if (changed) begin
        cnt <= 8'd1;
      end else if (cnt != STABLE) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ACQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (changed) begin
      state_nxt = ACQ;
    end else if (eval) begin
      state_nxt = HOLD;
    end
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (s_seg)
      7'h01:   dec_val = 4'h0;
      7'h4F:   dec_val = 4'h1;
      7'h12:   dec_val = 4'h2;
      7'h06:   dec_val = 4'h3;
      7'h4C:   dec_val = 4'h4;
      7'h24:   dec_val = 4'h5;
      7'h20:   dec_val = 4'h6;
      7'h0F:   dec_val = 4'h7;
      7'h00:   dec_val = 4'h8;
      7'h0C:   dec_val = 4'h9;
      7'h08:   dec_val = 4'hA;
      7'h60:   dec_val = 4'hB;
      7'h31:   dec_val = 4'hC;
      7'h42:   dec_val = 4'hD;
      7'h30:   dec_val = 4'hE;
      7'h38:   dec_val = 4'hF;
      default: dec_ok  = 1'b0;
    endcase
  end

  // Evaluation acts on the held sample; upd fires only on a visible change.
  always_comb begin
    left_nxt      = left;
    right_nxt     = right;
    left_vld_nxt  = left_vld;
    right_vld_nxt = right_vld;
    upd_nxt       = 1'b0;
    err_nxt       = 1'b0;
    if (eval) begin
      if (dec_ok) begin
        if (s_sel) begin
          upd_nxt       = !right_vld || (right != dec_val);
          right_nxt     = dec_val;
          right_vld_nxt = 1'b1;
        end else begin
          upd_nxt      = !left_vld || (left != dec_val);
          left_nxt     = dec_val;
          left_vld_nxt = 1'b1;
        end
      end else if (s_seg == BLANK) begin
        if (s_sel) begin
          upd_nxt       = right_vld;
          right_vld_nxt = 1'b0;
        end else begin
          upd_nxt      = left_vld;
          left_vld_nxt = 1'b0;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      left      <= 4'h0;
      right     <= 4'h0;
      left_vld  <= 1'b0;
      right_vld <= 1'b0;
      upd       <= 1'b0;
      err       <= 1'b0;
    end else begin
      left      <= left_nxt;
      right     <= right_nxt;
      left_vld  <= left_vld_nxt;
      right_vld <= right_vld_nxt;
      upd       <= upd_nxt;
      err       <= err_nxt;
    end
  end

`ifdef SEG_DEC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= 8'd0;
    end else if (err_nxt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_mux_decoder.sv
// tb/tb_seg_mux_decoder.sv - randomized bench for seg_mux_decoder against a run-length reference model.
// Directed sequences pin the model with literal expectations.
module tb_seg_mux_decoder;

  localparam int S = 4;

  logic       clk;
  logic       reset;
  logic [6:0] seg;
  logic       sel;
  logic [3:0] left;
  logic [3:0] right;
  logic       left_vld;
  logic       right_vld;
  logic       upd;
  logic       err;
`ifdef SEG_DEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  seg_mux_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk),
    .reset(reset),
    .seg(seg),
    .sel(sel),
    .left(left),
    .right(right),
    .left_vld(left_vld),
    .right_vld(right_vld),
    .upd(upd),
    .err(err)
`ifdef SEG_DEC_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  logic started = 1'b0;

  logic [6:0] codes [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Reference model: length of the current run of identical samples.
  int         m_len;
  logic [7:0] m_last;
  logic [3:0] m_left;
  logic [3:0] m_right;
  logic       m_lv;
  logic       m_rv;
  logic       m_upd;
  logic       m_err;
  logic [7:0] m_ecnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    if (p == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [11:0] apply_eval(input logic [7:0] smp, input logic [3:0] l,
                                             input logic [3:0] r, input logic lv, input logic rv);
    int d;
    logic u;
    logic e;
    d = decode(smp[6:0]);
    u = 1'b0;
    e = 1'b0;
    if (d >= 0 && d < 16) begin
      if (smp[7]) begin
        u = !rv || (r != d[3:0]);
        r = d[3:0];
        rv = 1'b1;
      end else begin
        u = !lv || (l != d[3:0]);
        l = d[3:0];
        lv = 1'b1;
      end
    end else if (d == 16) begin
      if (smp[7]) begin
        u = rv;
        rv = 1'b0;
      end else begin
        u = lv;
        lv = 1'b0;
      end
    end else begin
      e = 1'b1;
    end
    return {l, r, lv, rv, u, e};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_len   <= 0;
      m_last  <= 8'h7F;
      m_left  <= 4'h0;
      m_right <= 4'h0;
      m_lv    <= 1'b0;
      m_rv    <= 1'b0;
      m_upd   <= 1'b0;
      m_err   <= 1'b0;
      m_ecnt  <= 8'd0;
    end else begin
      if (m_len == S) begin
        {m_left, m_right, m_lv, m_rv, m_upd, m_err} <= apply_eval(m_last, m_left, m_right, m_lv, m_rv);
        if (decode(m_last[6:0]) < 0 && m_ecnt != 8'hFF) m_ecnt <= m_ecnt + 8'd1;
      end else begin
        m_upd <= 1'b0;
        m_err <= 1'b0;
      end
      if (m_len != 0 && {sel, seg} == m_last) m_len <= (m_len > S) ? m_len : m_len + 1;
      else m_len <= 1;
      m_last <= {sel, seg};
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_outputs", 32'({left, right, left_vld, right_vld, upd, err}),
          32'({m_left, m_right, m_lv, m_rv, m_upd, m_err}));
      chk("upd_err_exclusive", 32'(upd & err), 32'd0);
`ifdef SEG_DEC_ERRCNT_EN
      chk("model_err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
      if (upd) upd_seen++;
    end
  end

  task automatic drive(input logic s, input logic [6:0] p, input int n);
    sel = s;
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int u0;
    int r;
    logic [6:0] p;
    clk   = 1'b0;
    reset = 1'b0;
    sel   = 1'b0;
    seg   = 7'h7F;
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("reset_state", 32'({left, right, left_vld, right_vld, upd, err}), 32'd0);
`ifdef SEG_DEC_ERRCNT_EN
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    reset = 1'b1;

    drive(1'b0, 7'h12, 4);
    chk("left_not_yet", 32'(left_vld), 32'd0);
    drive(1'b0, 7'h12, 1);
    chk("left_2_accepted", 32'({left, left_vld, right_vld, upd}), 32'({4'h2, 1'b1, 1'b0, 1'b1}));
    drive(1'b0, 7'h12, 1);
    chk("upd_one_cycle", 32'(upd), 32'd0);

    drive(1'b1, 7'h38, 3);
    chk("glitch_no_action", 32'({right_vld, upd, err}), 32'd0);
    drive(1'b1, 7'h4F, 4);
    chk("right_not_yet", 32'(right_vld), 32'd0);
    drive(1'b1, 7'h4F, 1);
    chk("right_1_accepted", 32'({right, right_vld, upd}), 32'({4'h1, 1'b1, 1'b1}));
    drive(1'b1, 7'h4F, 1);
    chk("right_upd_one_cycle", 32'(upd), 32'd0);

    drive(1'b0, 7'h7E, 5);
    chk("illegal_err", 32'({err, upd, left, left_vld}), 32'({1'b1, 1'b0, 4'h2, 1'b1}));
`ifdef SEG_DEC_ERRCNT_EN
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
`endif
    drive(1'b0, 7'h7E, 1);
    chk("err_one_cycle", 32'(err), 32'd0);

    drive(1'b0, 7'h12, 5);
    chk("reacquire_no_upd", 32'({upd, left, left_vld}), 32'({1'b0, 4'h2, 1'b1}));
    drive(1'b0, 7'h7F, 5);
    chk("blank_clears_vld", 32'({left, left_vld, upd, err}), 32'({4'h2, 1'b0, 1'b1, 1'b0}));
    drive(1'b0, 7'h7F, 1);

    u0 = upd_seen;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'h06, 8);
      drive(1'b1, 7'h24, 8);
    end
    chk("alternate_digits", 32'({left, right, left_vld, right_vld}), 32'({4'h3, 4'h5, 1'b1, 1'b1}));
    chk("alternate_upd_count", 32'(upd_seen - u0), 32'd2);

    drive(1'b0, 7'h0C, 3);
    reset = 1'b0;
    drive(1'b0, 7'h0C, 1);
    chk("mid_acq_reset", 32'({left, right, left_vld, right_vld, upd, err}), 32'd0);
    reset = 1'b1;
    drive(1'b0, 7'h0C, 4);
    chk("restart_not_yet", 32'(left_vld), 32'd0);
    drive(1'b0, 7'h0C, 1);
    chk("restart_full_count", 32'({left, left_vld, upd}), 32'({4'h9, 1'b1, 1'b1}));

`ifdef SEG_DEC_ERRCNT_EN
    for (int i = 0; i < 300; i++) drive(1'b0, (i % 2 == 0) ? 7'h7E : 7'h7D, 5);
    chk("err_cnt_saturates", 32'(err_cnt), 32'd255);
`endif

    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) p = codes[$urandom_range(0, 15)];
      else if (r < 8) p = 7'h7F;
      else p = 7'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b0;
        drive(1'($urandom), p, 1);
        reset = 1'b1;
      end
      drive(1'($urandom), p, int'($urandom_range(1, 8)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
